// File: rtl/stopwatch_ctrl.sv
// Stopwatch control stage: synchronises and debounces the start/stop and clear buttons,
// then runs the IDLE/RUN/PAUSE machine that gates the 1 Hz tick and issues counter clears.
module stopwatch_ctrl #(
  parameter int DB_CYCLES = 65536,
  parameter int DB_W      = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_ss,
  input  logic       btn_clr,
  input  logic       tick_in,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       running,
  output logic [1:0] state_o
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;

  localparam logic [DB_W-1:0] DC_MAX = DB_W'(DB_CYCLES - 1);

  // Bit 0 carries start/stop, bit 1 carries clear throughout the button path.
  logic [1:0]      r_s1;
  logic [1:0]      r_s2;
  logic [1:0]      r_db;
  logic [1:0]      r_db_prev;
  logic [1:0]      r_press;
  logic [DB_W-1:0] r_dc [2];

  logic [1:0]      r_state;
  logic            r_cnt_clr;
  logic [1:0]      w_state_nxt;
  logic            w_clr_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_db      <= '0;
      r_db_prev <= '0;
      r_press   <= '0;
      r_dc[0]   <= '0;
      r_dc[1]   <= '0;
    end else begin
      r_s1      <= {btn_clr, btn_ss};
      r_s2      <= r_s1;
      r_db_prev <= r_db;
      r_press   <= r_db & ~r_db_prev;
      // Any sample that agrees with the accepted level restarts the stability count.
      for (int b = 0; b < 2; b++) begin
        if (r_s2[b] == r_db[b]) begin
          r_dc[b] <= '0;
        end else if (r_dc[b] == DC_MAX) begin
          r_db[b] <= r_s2[b];
          r_dc[b] <= '0;
        end else begin
          r_dc[b] <= r_dc[b] + DB_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr_nxt   = 1'b0;
    case (r_state)
      ST_IDLE, ST_PAUSE: begin
        if (r_press[1]) begin
          w_state_nxt = ST_IDLE;
          w_clr_nxt   = 1'b1;
        end else if (r_press[0]) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_press[1]) begin
          w_state_nxt = ST_IDLE;
          w_clr_nxt   = 1'b1;
        end else if (r_press[0]) begin
          w_state_nxt = ST_PAUSE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_clr_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt_clr <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt_clr <= w_clr_nxt;
    end
  end

  assign state_o = r_state;
  assign running = (r_state == ST_RUN);
  assign cnt_en  = tick_in & (r_state == ST_RUN);
  assign cnt_clr = r_cnt_clr;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus a randomised run
// compared cycle by cycle against a sample-history model of the button/FSM rules.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_ss = 1'b0;
  logic       btn_clr = 1'b0;
  logic       tick_in = 1'b0;
  logic       cnt_en;
  logic       cnt_clr;
  logic       running;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;

  stopwatch_ctrl #(.DB_CYCLES(4), .DB_W(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_ss  (btn_ss),
    .btn_clr (btn_clr),
    .tick_in (tick_in),
    .cnt_en  (cnt_en),
    .cnt_clr (cnt_clr),
    .running (running),
    .state_o (state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: 0 = IDLE, 1 = RUN, 2 = PAUSE; index 0 = start/stop, 1 = clear.
  int       m_state;
  bit       m_clr;
  bit [1:0] m_sync [2];
  bit [3:0] m_hist [2];
  bit       m_db   [2];
  bit [1:0] m_ev   [2];

  function automatic void model_reset();
    m_state = 0;
    m_clr   = 1'b0;
    for (int b = 0; b < 2; b++) begin
      m_sync[b] = '0;
      m_hist[b] = '0;
      m_db[b]   = 1'b0;
      m_ev[b]   = '0;
    end
  endfunction

  // A level is accepted once the last four synchronised samples all differ from it;
  // an accepted press reaches the state machine two clocks later.
  function automatic void model_step(input bit raw_ss, input bit raw_clr);
    bit raw [2];
    bit evnow [2];
    bit samp, rise;
    raw[0] = raw_ss;
    raw[1] = raw_clr;
    for (int b = 0; b < 2; b++) begin
      samp      = m_sync[b][1];
      m_sync[b] = {m_sync[b][0], raw[b]};
      m_hist[b] = {m_hist[b][2:0], samp};
      rise      = 1'b0;
      if (m_hist[b] == {4{~m_db[b]}}) begin
        rise    = ~m_db[b];
        m_db[b] = ~m_db[b];
      end
      evnow[b] = m_ev[b][1];
      m_ev[b]  = {m_ev[b][0], rise};
    end
    m_clr = evnow[1];
    if (evnow[1]) m_state = 0;
    else if (evnow[0]) m_state = (m_state == 1) ? 2 : 1;
  endfunction

  task automatic do_reset();
    reset   = 1'b1;
    btn_ss  = 1'b0;
    btn_clr = 1'b0;
    tick_in = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic hold_btns(input bit ss, input bit clr, input int n);
    btn_ss  = ss;
    btn_clr = clr;
    repeat (n) @(negedge clk);
    btn_ss  = 1'b0;
    btn_clr = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    tick_in = 1'b1;
    #1;
    checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL reset_state: got %b want 00", state_o); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", running); end
    checks++; if (cnt_en !== 1'b0) begin errors++; $display("FAIL reset_cnt_en: got %b want 0", cnt_en); end
    checks++; if (cnt_clr !== 1'b0) begin errors++; $display("FAIL reset_cnt_clr: got %b want 0", cnt_clr); end
    tick_in = 1'b0;
    @(negedge clk);
    hold_btns(1'b1, 1'b0, 12);
    checks++; if (state_o !== 2'b01) begin errors++; $display("FAIL reset_setup_run: got %b want 01", state_o); end
    @(posedge clk);
    #2;
    reset   = 1'b1;
    tick_in = 1'b1;
    #1;
    checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL async_reset_state: got %b want 00", state_o); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL async_reset_running: got %b want 0", running); end
    checks++; if (cnt_en !== 1'b0) begin errors++; $display("FAIL async_reset_cnt_en: got %b want 0", cnt_en); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tick_in = i[0];
      #1;
      checks++; if (cnt_en !== 1'b0) begin errors++; $display("FAIL post_reset_cnt_en[%0d]: got %b want 0", i, cnt_en); end
    end
    tick_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_latency();
    logic [1:0] exp;
    btn_ss = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp = (k >= 8) ? 2'b01 : 2'b00;
      checks++; if (state_o !== exp) begin errors++; $display("FAIL latency_state[k=%0d]: got %b want %b", k, state_o, exp); end
    end
    tick_in = 1'b1;
    #1;
    checks++; if (cnt_en !== 1'b1) begin errors++; $display("FAIL run_cnt_en_hi: got %b want 1", cnt_en); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL run_running: got %b want 1", running); end
    tick_in = 1'b0;
    #1;
    checks++; if (cnt_en !== 1'b0) begin errors++; $display("FAIL run_cnt_en_lo: got %b want 0", cnt_en); end
    @(negedge clk);
    btn_ss = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_bounce();
    int lv  [4] = '{1, 0, 1, 0};
    int dur [4] = '{2, 1, 3, 2};
    int changes = 0;
    logic [1:0] prev;
    prev = state_o;
    for (int s = 0; s < 4; s++) begin
      btn_ss = lv[s][0];
      repeat (dur[s]) begin
        @(negedge clk);
        if (state_o !== prev) changes++;
        prev = state_o;
      end
    end
    btn_ss = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (state_o !== prev) changes++;
      prev = state_o;
      if (k == 7) begin
        checks++; if (state_o !== 2'b01) begin errors++; $display("FAIL bounce_early: got %b want 01", state_o); end
      end
      if (k == 8) begin
        checks++; if (state_o !== 2'b10) begin errors++; $display("FAIL bounce_accept: got %b want 10", state_o); end
      end
    end
    checks++; if (changes !== 1) begin errors++; $display("FAIL bounce_transitions: got %0d want 1", changes); end
    btn_ss = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_pause();
    tick_in = 1'b1;
    #1;
    checks++; if (cnt_en !== 1'b0) begin errors++; $display("FAIL pause_cnt_en: got %b want 0", cnt_en); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL pause_running: got %b want 0", running); end
    tick_in = 1'b0;
    @(negedge clk);
    hold_btns(1'b1, 1'b0, 12);
    checks++; if (state_o !== 2'b01) begin errors++; $display("FAIL resume_state: got %b want 01", state_o); end
    tick_in = 1'b1;
    #1;
    checks++; if (cnt_en !== 1'b1) begin errors++; $display("FAIL resume_cnt_en: got %b want 1", cnt_en); end
    tick_in = 1'b0;
    @(negedge clk);
    hold_btns(1'b1, 1'b0, 12);
    checks++; if (state_o !== 2'b10) begin errors++; $display("FAIL repause_state: got %b want 10", state_o); end
  endtask

  task automatic test_clear();
    logic [1:0] pre;
    int nclr;
    for (int pass = 0; pass < 2; pass++) begin
      pre     = (pass == 0) ? 2'b10 : 2'b00;
      nclr    = 0;
      btn_clr = 1'b1;
      for (int k = 1; k <= 12; k++) begin
        @(negedge clk);
        if (k == 7) begin
          checks++; if (state_o !== pre) begin errors++; $display("FAIL clear_pre[%0d]: got %b want %b", pass, state_o, pre); end
        end
        if (cnt_clr === 1'b1) begin
          nclr++;
          checks++; if (k != 8 || state_o !== 2'b00) begin errors++; $display("FAIL clear_pulse_at[%0d]: got k=%0d state=%b want k=8 state=00", pass, k, state_o); end
        end
      end
      checks++; if (nclr !== 1) begin errors++; $display("FAIL clear_count[%0d]: got %0d want 1", pass, nclr); end
      checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL clear_state[%0d]: got %b want 00", pass, state_o); end
      btn_clr = 1'b0;
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic test_simultaneous();
    int nclr = 0;
    bit saw_pause = 1'b0;
    hold_btns(1'b1, 1'b0, 12);
    checks++; if (state_o !== 2'b01) begin errors++; $display("FAIL simul_setup: got %b want 01", state_o); end
    btn_ss  = 1'b1;
    btn_clr = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (state_o === 2'b10) saw_pause = 1'b1;
      if (cnt_clr === 1'b1) nclr++;
    end
    checks++; if (saw_pause !== 1'b0) begin errors++; $display("FAIL simul_pause_seen: got %b want 0", saw_pause); end
    checks++; if (nclr !== 1) begin errors++; $display("FAIL simul_clr_count: got %0d want 1", nclr); end
    checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL simul_state: got %b want 00", state_o); end
    btn_ss  = 1'b0;
    btn_clr = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_random();
    int ss_left = 0;
    int clr_left = 20;
    logic [1:0] exp_state;
    do_reset();
    model_reset();
    for (int i = 0; i < 1500; i++) begin
      exp_state = 2'(m_state);
      #1;
      checks++; if (state_o !== exp_state) begin errors++; $display("FAIL rand_state[%0d]: got %b want %b", i, state_o, exp_state); end
      checks++; if (running !== (m_state == 1)) begin errors++; $display("FAIL rand_running[%0d]: got %b want %b", i, running, (m_state == 1)); end
      checks++; if (cnt_en !== (tick_in & (m_state == 1))) begin errors++; $display("FAIL rand_cnt_en[%0d]: got %b want %b", i, cnt_en, tick_in & (m_state == 1)); end
      checks++; if (cnt_clr !== m_clr) begin errors++; $display("FAIL rand_cnt_clr[%0d]: got %b want %b", i, cnt_clr, m_clr); end
      if (ss_left == 0) begin
        btn_ss  = ~btn_ss;
        ss_left = int'($urandom_range(1, 14));
      end
      ss_left--;
      if (clr_left == 0) begin
        btn_clr  = ~btn_clr;
        clr_left = btn_clr ? int'($urandom_range(1, 10)) : int'($urandom_range(15, 60));
      end
      clr_left--;
      tick_in = ($urandom_range(0, 3) == 0);
      @(posedge clk);
      model_step(btn_ss, btn_clr);
      @(negedge clk);
    end
    btn_ss  = 1'b0;
    btn_clr = 1'b0;
    tick_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_bounce();
    test_pause();
    test_clear();
    test_simultaneous();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
